seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller. Holds a frame of NUM_DIGITS 4-bit digit codes with per-digit decimal points and scans them onto one shared active-low segment bus with active-low digit enables. Adds tear-free frame loading, leading-zero blanking and a frame strobe. Sits between the counter/datapath logic and the board LED pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV, 100000, clk cycles each digit stays selected (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
load  in  1  capture digits_in/dp_in into the shadow frame this cycle
digits_in  in  4*NUM_DIGITS  digit codes; [3:0] is digit 0 (rightmost)
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_lz_en  in  1  enable leading-zero blanking
disp_en  in  1  0 = all digits dark, scanning continues
seg_out  out  8  {a,b,c,d,e,f,g,dp}, active-low
an_out  out  NUM_DIGITS  digit enables, active-low, one-hot-low while displaying
frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset: prescaler=0, index=0, active and shadow frames all zero, dp all zero, pending=0, seg_out=8'hFF, an_out=all ones, frame_done=0.
- Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it returns to 0 and index advances; NUM_DIGITS-1 wraps to 0 (the frame boundary).
- seg_out/an_out are registered from the current index and active frame: one-cycle latency after an index change.
- Encoding of code 0-9, dp off: 0=0000001_1, 1=1001111_1, 2=0010010_1, 3=0000110_1, 4=1001100_1, 5=0100100_1, 6=0100000_1, 7=0001111_1, 8=0000000_1, 9=0000100_1. dp bit is 0 when the digit's dp is set.
- Codes 10-15 without HEX_EN: segments a-g off and dp forced lit (8'b11111110), regardless of dp_in.
- load=1: shadow <= digits_in/dp_in and pending <= 1. Active frame unchanged until the boundary.
- At the frame boundary: if pending, active <= shadow and pending <= 0. frame_done pulses for 1 cycle on the same edge, whether pending or not.
- load coinciding with the boundary: the old shadow commits, the new data enters shadow and pending stays 1. The new data commits at the next boundary.
- Leading-zero blanking, with blank_lz_en=1: scanning from digit NUM_DIGITS-1 downward, each digit whose active code is 0 and whose dp is clear is blanked (seg_out=8'hFF) until the first nonzero code or dp-set digit. Digit 0 is never blanked. Blanking is evaluated on the active frame only.
- disp_en=0: seg_out=8'hFF and an_out=all ones from the next edge. Prescaler, index, loading and frame_done continue unaffected.
- Counter widths are $clog2 of their ranges, minimum 1 bit. There are no undefined index states: an index >= NUM_DIGITS is unreachable and is decoded as all digits off.

Optional Feature:
HEX_EN. When defined, codes 10-15 display hex glyphs: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 (a..g), with dp following dp_in. When undefined, they use the dp-only pattern above.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, reset then release -> seg_out=8'hFF and an_out=4'b1111 during reset; an_out steps 1110,1101,1011,0111 every 4 cycles; frame_done pulses once per 16 cycles.
- load with digits_in=16'h1234 mid-frame -> display unchanged until wrap; next frame shows digit0=4 (10011001), digit3=1 (10011111).
- blank_lz_en=1, digits_in=16'h0050, dp_in=0 -> digits 3 and 2 output 8'hFF, digit1=5 (01001001), digit0=0 (00000011). Repeat with dp_in[3]=1 -> digit3 shows 00000010 and digit2 is not blanked.
- Code 4'hA on digit 0 -> 8'b11111110 without HEX_EN; 8'b00010001 with HEX_EN and dp_in=0.
- load asserted on the boundary cycle twice in consecutive frames -> each commit is delayed exactly one frame; pending clears after the second commit.
- rst_n low mid-frame with the active frame loaded -> outputs return to 8'hFF/all ones immediately; the display shows zeros after release.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: frame load inputs, display controls and
// the active-low segment/anode pins plus the frame strobe.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                         load;
  logic [NUM_DIGITS-1:0][3:0]   digits_in;
  logic [NUM_DIGITS-1:0]        dp_in;
  logic                         blank_lz_en;
  logic                         disp_en;
  logic [7:0]                   seg_out;
  logic [NUM_DIGITS-1:0]        an_out;
  logic                         frame_done;

  modport master (
    output load, digits_in, dp_in, blank_lz_en, disp_en,
    input  seg_out, an_out, frame_done
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz_en, disp_en,
    output seg_out, an_out, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with shadow-frame loading, leading-zero blanking
// and a frame strobe. Define HEX_EN to show glyphs A-F for codes 10-15.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PSC = PW'(SCAN_DIV - 1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] code;
    logic [NUM_DIGITS-1:0]      dp;
  } frame_t;

  frame_t                active, shadow;
  logic                  pending;
  logic [PW-1:0]         psc;
  logic [IW-1:0]         idx;
  logic                  step, wrap;
  logic [NUM_DIGITS-1:0] blank;
  logic                  run;
  logic [7:0]            seg_nxt, seg_q;
  logic [NUM_DIGITS-1:0] an_nxt, an_q;
  logic                  done_q;

  function automatic logic [7:0] encode(input logic [3:0] code, input logic dp);
    logic [7:0] r;
    r = {7'h7F, ~dp};
    case (code)
      4'd0:  r[7:1] = 7'b0000001;
      4'd1:  r[7:1] = 7'b1001111;
      4'd2:  r[7:1] = 7'b0010010;
      4'd3:  r[7:1] = 7'b0000110;
      4'd4:  r[7:1] = 7'b1001100;
      4'd5:  r[7:1] = 7'b0100100;
      4'd6:  r[7:1] = 7'b0100000;
      4'd7:  r[7:1] = 7'b0001111;
      4'd8:  r[7:1] = 7'b0000000;
      4'd9:  r[7:1] = 7'b0000100;
`ifdef HEX_EN
      4'd10: r[7:1] = 7'b0001000;
      4'd11: r[7:1] = 7'b1100000;
      4'd12: r[7:1] = 7'b0110001;
      4'd13: r[7:1] = 7'b1000010;
      4'd14: r[7:1] = 7'b0110000;
      4'd15: r[7:1] = 7'b0111000;
`else
      // Out-of-range codes show a lone dp so a bad value is still visible.
      default: r = 8'hFE;
`endif
    endcase
    return r;
  endfunction

  assign step = (psc == LAST_PSC);
  assign wrap = step && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc     <= '0;
      idx     <= '0;
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      psc    <= step ? '0 : psc + PW'(1);
      done_q <= wrap;
      if (step) idx <= wrap ? '0 : idx + IW'(1);
      if (wrap && pending) active <= shadow;
      // A load on the wrap cycle wins: old shadow commits, new data waits a frame.
      if (bus.load) begin
        shadow.code <= bus.digits_in;
        shadow.dp   <= bus.dp_in;
        pending     <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Blank zeros from the top digit down until a significant digit or a lit dp.
  always_comb begin
    blank = '0;
    run   = bus.blank_lz_en;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run      = run & (active.code[i] == 4'd0) & ~active.dp[i];
      blank[i] = run;
    end
  end

  always_comb begin
    seg_nxt = 8'hFF;
    an_nxt  = '1;
    if (bus.disp_en && (int'(idx) < NUM_DIGITS)) begin
      an_nxt[idx] = 1'b0;
      if (!blank[idx]) seg_nxt = encode(active.code[idx], active.dp[idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 8'hFF;
      an_q  <= '1;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = done_q;
endmodule
